// File: rtl/rr_arb7_pkg.sv
// rr_arb7 shared types: requester count, lock FSM states, pointer type.
// Pointer helpers used by the arbiter.
package rr_arb7_pkg;

  localparam int NREQ = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic [2:0] ptr_t;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(NREQ - 1)) ? '0 : p + 3'd1;
  endfunction

  function automatic ptr_t oh2idx(logic [NREQ-1:0] oh);
    ptr_t r;
    r = '0;
    for (int i = 0; i < NREQ; i++)
      if (oh[i]) r = ptr_t'(i);
    return r;
  endfunction

endpackage

// File: rtl/mux7.sv
// Common 7-input one-hot AND-OR mux cell.
// Selects are assumed one-hot or zero; zero selects give zero.
module mux7 #(
  parameter int DW = 32
) (
  input  logic          sel6,
  input  logic          sel5,
  input  logic          sel4,
  input  logic          sel3,
  input  logic          sel2,
  input  logic          sel1,
  input  logic          sel0,
  input  logic [DW-1:0] d6,
  input  logic [DW-1:0] d5,
  input  logic [DW-1:0] d4,
  input  logic [DW-1:0] d3,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d0,
  output logic [DW-1:0] y
);

  assign y = ({DW{sel6}} & d6) | ({DW{sel5}} & d5)
           | ({DW{sel4}} & d4) | ({DW{sel3}} & d3)
           | ({DW{sel2}} & d2) | ({DW{sel1}} & d1)
           | ({DW{sel0}} & d0);

endmodule

// File: rtl/rr_arb7.sv
// 7-way round-robin arbiter with registered output slice.
// Define RR_ARB7_LOCK_EN to hold the grant for multi-beat packets.
module rr_arb7
  import rr_arb7_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [NREQ-1:0]   in_valid,
  input  logic [NREQ*DW-1:0] in_data,
`ifdef RR_ARB7_LOCK_EN
  input  logic [NREQ-1:0]   in_last,
`endif
  output logic [NREQ-1:0]   in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [NREQ-1:0]   out_sel
);

  ptr_t            ptr;
  ptr_t            idx;
  ptr_t            gnt_idx;
  logic            found;
  logic [NREQ-1:0] rr_gnt;
  logic [NREQ-1:0] gnt;
  logic            load;
  logic            xfer;
  logic            xfer_last;
  logic [DW-1:0]   mux_y;

  // Rotating priority search starting at ptr
  always_comb begin
    rr_gnt = '0;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && in_valid[idx]) begin
        rr_gnt[idx] = 1'b1;
        found       = 1'b1;
      end
      idx = ptr_inc(idx);
    end
  end

`ifdef RR_ARB7_LOCK_EN
  state_t state;
  state_t state_nxt;
  ptr_t   owner;

  // Lock state register
  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Record the packet owner on its first non-final beat
  always_ff @(posedge clk) begin
    if (!nreset)
      owner <= '0;
    else if (state == IDLE && xfer && !xfer_last)
      owner <= gnt_idx;
  end

  // Lock next-state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (xfer && !xfer_last) state_nxt = LOCKED;
      LOCKED: if (xfer && xfer_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant: owner only while locked, else round-robin
  always_comb begin
    gnt = rr_gnt;
    if (state == LOCKED) begin
      gnt        = '0;
      gnt[owner] = 1'b1;
    end
  end

  assign xfer_last = |(in_last & gnt);
`else
  assign gnt       = rr_gnt;
  assign xfer_last = 1'b1;
`endif

  assign load     = !out_valid || out_ready;
  assign in_ready = gnt & {NREQ{load & nreset}};
  assign xfer     = |(in_valid & in_ready);
  assign gnt_idx  = oh2idx(gnt);

  mux7 #(.DW(DW)) u_mux (
    .sel6 (gnt[6]),
    .sel5 (gnt[5]),
    .sel4 (gnt[4]),
    .sel3 (gnt[3]),
    .sel2 (gnt[2]),
    .sel1 (gnt[1]),
    .sel0 (gnt[0]),
    .d6   (in_data[6*DW +: DW]),
    .d5   (in_data[5*DW +: DW]),
    .d4   (in_data[4*DW +: DW]),
    .d3   (in_data[3*DW +: DW]),
    .d2   (in_data[2*DW +: DW]),
    .d1   (in_data[1*DW +: DW]),
    .d0   (in_data[0*DW +: DW]),
    .y    (mux_y)
  );

  // Output slice: load on free slot or drain, hold on stall
  always_ff @(posedge clk) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= mux_y;
        out_sel  <= gnt;
        out_last <= xfer_last;
      end else begin
        out_sel  <= '0;
      end
    end
  end

  // Advance pointer past the winner after a packet-final beat
  always_ff @(posedge clk) begin
    if (!nreset)
      ptr <= '0;
    else if (xfer && xfer_last)
      ptr <= ptr_inc(gnt_idx);
  end

endmodule

// File: tb/tb_rr_arb7.sv
// Directed self-checking bench for rr_arb7.
// Lock scenarios run only when RR_ARB7_LOCK_EN is defined.
module tb_rr_arb7;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          nreset;
  logic [6:0]    in_valid;
  logic [7*DW-1:0] in_data;
`ifdef RR_ARB7_LOCK_EN
  logic [6:0]    in_last;
`endif
  logic [6:0]    in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [6:0]    out_sel;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_arb7 #(.DW(DW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_ARB7_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset    = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++)
      in_data[i*DW +: DW] = 32'hD000_0000 + i;
`ifdef RR_ARB7_LOCK_EN
    in_last = 7'h7F;
`endif

    tick();
    tick();
    in_valid = 7'h22;
    #1;
    chk("rst_rdy",  32'(in_ready),  32'h0);
    chk("rst_vld",  32'(out_valid), 32'h0);
    chk("rst_data", out_data,       32'h0);
    chk("rst_sel",  32'(out_sel),   32'h0);
    chk("rst_last", 32'(out_last),  32'h0);
    in_valid  = '0;
    nreset    = 1'b1;
    out_ready = 1'b1;

    // full round-robin sweep 0..6,0
    in_valid = 7'h7F;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_rdy", 32'(in_ready), 32'(1 << (k % 7)));
      tick();
      chk("rr_vld",  32'(out_valid), 32'h1);
      chk("rr_sel",  32'(out_sel),   32'(1 << (k % 7)));
      chk("rr_data", out_data,       32'hD000_0000 + 32'(k % 7));
    end
    chk("rr_last", 32'(out_last), 32'h1);
    in_valid = '0;
    tick();
    chk("drain_vld", 32'(out_valid), 32'h0);
    chk("drain_sel", 32'(out_sel),   32'h0);

    // wrap 6 -> 0 -> ptr 1
    in_valid = 7'h40;
    #1;
    chk("wrap6_rdy", 32'(in_ready), 32'h40);
    tick();
    chk("wrap6_sel", 32'(out_sel), 32'h40);
    in_valid = 7'h01;
    #1;
    chk("wrap0_rdy", 32'(in_ready), 32'h01);
    tick();
    chk("wrap0_sel", 32'(out_sel), 32'h01);
    in_valid = 7'h41;
    #1;
    chk("ptr1_rdy", 32'(in_ready), 32'h40);
    in_valid = '0;
    tick();
    chk("idle_vld", 32'(out_valid), 32'h0);

    // stall with A5 beat held for 5 cycles
    out_ready = 1'b0;
    in_data[3*DW +: DW] = 32'hA5A5_A5A5;
    in_valid = 7'h08;
    #1;
    chk("st_load_rdy", 32'(in_ready), 32'h08);
    tick();
    chk("st_load_data", out_data, 32'hA5A5_A5A5);
    in_data[4*DW +: DW] = 32'h5A5A_5A5A;
    in_valid = 7'h10;
    repeat (5) begin
      #1;
      chk("st_rdy",  32'(in_ready),  32'h0);
      chk("st_vld",  32'(out_valid), 32'h1);
      chk("st_data", out_data,       32'hA5A5_A5A5);
      chk("st_sel",  32'(out_sel),   32'h08);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("st_rel_rdy", 32'(in_ready), 32'h10);
    tick();
    chk("st_rel_data", out_data,     32'h5A5A_5A5A);
    chk("st_rel_sel",  32'(out_sel), 32'h10);
    in_valid = '0;
    tick();

`ifdef RR_ARB7_LOCK_EN
    // req 2 three-beat packet while req 3 waits (ptr=5)
    in_valid = 7'h0C;
    in_last  = 7'h00;
    #1;
    chk("lk_b1_rdy", 32'(in_ready), 32'h04);
    tick();
    chk("lk_b1_last", 32'(out_last), 32'h0);
    chk("lk_b1_sel",  32'(out_sel),  32'h04);
    #1;
    chk("lk_b2_rdy", 32'(in_ready), 32'h04);
    tick();
    in_last = 7'h04;
    #1;
    chk("lk_b3_rdy", 32'(in_ready), 32'h04);
    tick();
    chk("lk_b3_last", 32'(out_last), 32'h1);
    #1;
    chk("lk_after_rdy", 32'(in_ready), 32'h08);
    in_valid = '0;
    tick();

    // owner pauses mid-packet (ptr=3)
    in_valid = 7'h04;
    in_last  = 7'h00;
    #1;
    chk("gap_b1_rdy", 32'(in_ready), 32'h04);
    tick();
    in_valid = 7'h08;
    repeat (3) begin
      #1;
      chk("gap_hold_rdy", 32'(in_ready), 32'h04);
      tick();
    end
    in_valid = 7'h0C;
    in_last  = 7'h04;
    #1;
    chk("gap_end_rdy", 32'(in_ready), 32'h04);
    tick();
    chk("gap_end_sel",  32'(out_sel),  32'h04);
    chk("gap_end_last", 32'(out_last), 32'h1);
    in_valid = 7'h08;
    #1;
    chk("gap_free_rdy", 32'(in_ready), 32'h08);
    in_valid = '0;
    tick();
    in_last = 7'h00;
`endif

    // reset mid-stream, then ptr=0 ordering
    in_valid = 7'h08;
    #1;
    chk("pre_rst_rdy", 32'(in_ready), 32'h08);
    tick();
    nreset   = 1'b0;
    in_valid = 7'h22;
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("mid_rst_vld",  32'(out_valid), 32'h0);
    chk("mid_rst_data", out_data,       32'h0);
    chk("mid_rst_sel",  32'(out_sel),   32'h0);
    chk("mid_rst_last", 32'(out_last),  32'h0);
    nreset = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(in_ready), 32'h02);
    tick();
    chk("post_rst_sel",  32'(out_sel), 32'h02);
    chk("post_rst_data", out_data,     32'hD000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
